// File: rtl/micro_seq_pkg.sv
// Shared definitions for the Am2910-class microprogram sequencer:
// sequence opcodes and default geometry.
package micro_seq_pkg;

    localparam int SEQ_AW    = 8;
    localparam int SEQ_DEPTH = 5;

    typedef enum logic [3:0] {
        OP_JZ   = 4'd0,
        OP_CJS  = 4'd1,
        OP_JMAP = 4'd2,
        OP_CJP  = 4'd3,
        OP_PUSH = 4'd4,
        OP_JSRP = 4'd5,
        OP_CJV  = 4'd6,
        OP_JRP  = 4'd7,
        OP_RFCT = 4'd8,
        OP_RPCT = 4'd9,
        OP_CRTN = 4'd10,
        OP_CJPP = 4'd11,
        OP_LDCT = 4'd12,
        OP_LOOP = 4'd13,
        OP_CONT = 4'd14,
        OP_TWB  = 4'd15
    } seq_op_t;

endpackage

// File: rtl/seq_stack.sv
// Subroutine/loop LIFO. Push when full overwrites the top entry;
// pop when empty is ignored; clear only resets the pointer.
module seq_stack #(
    parameter int AW    = 8,
    parameter int DEPTH = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  logic [AW-1:0] din,
    output logic [AW-1:0] tos,
    output logic          full,
    output logic          empty
);

    localparam int SPW = $clog2(DEPTH + 1);
    localparam logic [SPW-1:0] SP_ONE   = SPW'(1);
    localparam logic [SPW-1:0] SP_DEPTH = SPW'(DEPTH);
    localparam logic [SPW-1:0] SP_LAST  = SPW'(DEPTH - 1);

    logic [AW-1:0]  stk_r [DEPTH];
    logic [SPW-1:0] sp_r;
    logic [SPW-1:0] wr_idx_s;

    assign full  = (sp_r == SP_DEPTH);
    assign empty = (sp_r == {SPW{1'b0}});

    // Top-of-stack view and write slot (a full stack rewrites its top entry)
    always_comb begin
        tos      = {AW{1'b0}};
        wr_idx_s = sp_r;
        if (empty) begin
            tos = {AW{1'b0}};
        end else begin
            tos = stk_r[sp_r - SP_ONE];
        end
        if (full) begin
            wr_idx_s = SP_LAST;
        end else begin
            wr_idx_s = sp_r;
        end
    end

    // Pointer and storage update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_r <= {SPW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                stk_r[i] <= {AW{1'b0}};
            end
        end else if (clear) begin
            sp_r <= {SPW{1'b0}};
        end else if (push) begin
            stk_r[wr_idx_s] <= din;
            if (!full) begin
                sp_r <= sp_r + SP_ONE;
            end
        end else if (pop && !empty) begin
            sp_r <= sp_r - SP_ONE;
        end
    end

endmodule

// File: rtl/micro_sequencer.sv
// Am2910-class microprogram sequencer: selects the next microaddress from
// upc, d, the loop counter or the stack per the 4-bit sequence instruction.
module micro_sequencer
    import micro_seq_pkg::*;
#(
    parameter int AW    = SEQ_AW,
    parameter int DEPTH = SEQ_DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    inst,
    input  logic          cond,
    input  logic          ci,
    input  logic [AW-1:0] d,
    output logic [AW-1:0] y,
    output logic          pl_en,
    output logic          map_en,
    output logic          vect_en,
    output logic          full
);

    logic [AW-1:0] upc_r;
    logic [AW-1:0] r_r;
    logic [AW-1:0] tos_s;
    logic [AW-1:0] y_s;
    logic          push_s, pop_s, clear_s, load_r_s, dec_r_s;
    logic          pl_s, map_s, vect_s;
    logic          empty_s;
    logic          r_zero_s;

    assign r_zero_s = (r_r == {AW{1'b0}});

    // Opcode decode: next-address select and stack/counter side effects
    always_comb begin
        y_s      = upc_r;
        push_s   = 1'b0;
        pop_s    = 1'b0;
        clear_s  = 1'b0;
        load_r_s = 1'b0;
        dec_r_s  = 1'b0;
        case (seq_op_t'(inst))
            OP_JZ:   begin y_s = {AW{1'b0}}; clear_s = 1'b1; end
            OP_CJS:  begin y_s = cond ? d : upc_r; push_s = cond; end
            OP_JMAP: y_s = d;
            OP_CJP:  y_s = cond ? d : upc_r;
            OP_PUSH: begin y_s = upc_r; push_s = 1'b1; load_r_s = cond; end
            OP_JSRP: begin y_s = cond ? d : r_r; push_s = 1'b1; end
            OP_CJV:  y_s = cond ? d : upc_r;
            OP_JRP:  y_s = cond ? d : r_r;
            OP_RFCT: begin
                if (r_zero_s) begin
                    y_s = upc_r; pop_s = 1'b1;
                end else begin
                    y_s = tos_s; dec_r_s = 1'b1;
                end
            end
            OP_RPCT: begin
                if (r_zero_s) begin
                    y_s = upc_r;
                end else begin
                    y_s = d; dec_r_s = 1'b1;
                end
            end
            OP_CRTN: begin y_s = cond ? tos_s : upc_r; pop_s = cond; end
            OP_CJPP: begin y_s = cond ? d : upc_r; pop_s = cond; end
            OP_LDCT: begin y_s = upc_r; load_r_s = 1'b1; end
            OP_LOOP: begin y_s = cond ? upc_r : tos_s; pop_s = cond; end
            OP_CONT: y_s = upc_r;
            OP_TWB: begin
                if (cond) begin
                    y_s = upc_r; pop_s = 1'b1;
                end else if (!r_zero_s) begin
                    y_s = tos_s; dec_r_s = 1'b1;
                end else begin
                    y_s = d; pop_s = 1'b1;
                end
            end
            default: y_s = upc_r;
        endcase
    end

    // One-hot source enable for the d bus
    always_comb begin
        pl_s   = 1'b0;
        map_s  = 1'b0;
        vect_s = 1'b0;
        case (seq_op_t'(inst))
            OP_JMAP: map_s  = 1'b1;
            OP_CJV:  vect_s = 1'b1;
            default: pl_s   = 1'b1;
        endcase
    end

    // Outputs are forced to their idle values while reset is asserted
    assign y       = rst_n ? y_s : {AW{1'b0}};
    assign pl_en   = rst_n ? pl_s : 1'b1;
    assign map_en  = rst_n & map_s;
    assign vect_en = rst_n & vect_s;

    // Microprogram counter and loop counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upc_r <= {AW{1'b0}};
            r_r   <= {AW{1'b0}};
        end else begin
            upc_r <= y_s + {{(AW-1){1'b0}}, ci};
            if (load_r_s) begin
                r_r <= d;
            end else if (dec_r_s) begin
                r_r <= r_r - {{(AW-1){1'b0}}, 1'b1};
            end
        end
    end

    seq_stack #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .clear (clear_s),
        .din   (upc_r),
        .tos   (tos_s),
        .full  (full),
        .empty (empty_s)
    );

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed self-checking bench for micro_sequencer (AW=8, DEPTH=5).
module tb_micro_sequencer;
    import micro_seq_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [3:0] inst;
    logic       cond;
    logic       ci;
    logic [7:0] d;
    logic [7:0] y;
    logic       pl_en, map_en, vect_en, full;

    int tests_run = 0;
    int fails     = 0;

    micro_sequencer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .inst    (inst),
        .cond    (cond),
        .ci      (ci),
        .d       (d),
        .y       (y),
        .pl_en   (pl_en),
        .map_en  (map_en),
        .vect_en (vect_en),
        .full    (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input seq_op_t op, input logic c, input logic cin, input logic [7:0] dv);
        inst = op; cond = c; ci = cin; d = dv;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Checks y against an expected address and counts the comparison
    task automatic test_reset();
        logic [7:0] exp_seq [3];
        exp_seq[0] = 8'h00; exp_seq[1] = 8'h01; exp_seq[2] = 8'h02;
        rst_n = 1'b0;
        drive(OP_JMAP, 1'b1, 1'b1, 8'h5A);
        tests_run++;
        if (y !== 8'h00 || pl_en !== 1'b1 || map_en !== 1'b0 || full !== 1'b0) begin
            fails++; $display("FAIL reset_idle: y=%h pl=%b map=%b full=%b expected y=00 pl=1 map=0 full=0", y, pl_en, map_en, full);
        end
        @(negedge clk); rst_n = 1'b1;
        drive(OP_LDCT, 1'b0, 1'b1, 8'h03); tick();
        drive(OP_PUSH, 1'b0, 1'b1, 8'h00); tick();
        drive(OP_PUSH, 1'b0, 1'b1, 8'h00); tick();
        drive(OP_RFCT, 1'b0, 1'b1, 8'h00);
        tests_run++;
        if (y !== 8'h02) begin fails++; $display("FAIL rfct_before_reset: y=%h expected %h", y, 8'h02); end
        rst_n = 1'b0; #1;
        tests_run++;
        if (y !== 8'h00 || full !== 1'b0 || pl_en !== 1'b1) begin
            fails++; $display("FAIL reset_midrun: y=%h full=%b pl=%b expected y=00 full=0 pl=1", y, full, pl_en);
        end
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(OP_CONT, 1'b0, 1'b1, 8'h00);
            tests_run++;
            if (y !== exp_seq[i]) begin fails++; $display("FAIL cont_after_reset[%0d]: y=%h expected %h", i, y, exp_seq[i]); end
            tick();
        end
        drive(OP_CRTN, 1'b1, 1'b1, 8'h00);
        tests_run++;
        if (y !== 8'h00) begin fails++; $display("FAIL stack_cleared: y=%h expected %h", y, 8'h00); end
        tick();
        drive(OP_RFCT, 1'b0, 1'b1, 8'h00);
        tests_run++;
        if (y !== 8'h01) begin fails++; $display("FAIL counter_cleared: y=%h expected %h", y, 8'h01); end
        tick();
    endtask

    task automatic test_subroutine();
        do_reset();
        drive(OP_CJP, 1'b1, 1'b1, 8'h0F); tick();
        drive(OP_CJS, 1'b0, 1'b0, 8'h40);
        tests_run++;
        if (y !== 8'h10) begin fails++; $display("FAIL cjs_fail: y=%h expected %h", y, 8'h10); end
        tick();
        drive(OP_CJS, 1'b1, 1'b1, 8'h40);
        tests_run++;
        if (y !== 8'h40) begin fails++; $display("FAIL cjs_pass: y=%h expected %h", y, 8'h40); end
        tick();
        drive(OP_CONT, 1'b0, 1'b1, 8'h00); tick();
        drive(OP_CRTN, 1'b0, 1'b1, 8'h00);
        tests_run++;
        if (y !== 8'h42) begin fails++; $display("FAIL crtn_fail: y=%h expected %h", y, 8'h42); end
        tick();
        drive(OP_CRTN, 1'b1, 1'b1, 8'h00);
        tests_run++;
        if (y !== 8'h10) begin fails++; $display("FAIL crtn_pass: y=%h expected %h", y, 8'h10); end
        tick();
        drive(OP_CRTN, 1'b1, 1'b1, 8'h00);
        tests_run++;
        if (y !== 8'h00) begin fails++; $display("FAIL crtn_empty: y=%h expected %h", y, 8'h00); end
        tick();
    endtask

    task automatic test_counted_loop();
        logic [7:0] exp_seq [3];
        exp_seq[0] = 8'h20; exp_seq[1] = 8'h20; exp_seq[2] = 8'h21;
        do_reset();
        drive(OP_CJP, 1'b1, 1'b1, 8'h1E); tick();
        drive(OP_LDCT, 1'b0, 1'b1, 8'h02); tick();
        drive(OP_PUSH, 1'b0, 1'b1, 8'h00);
        tests_run++;
        if (y !== 8'h20) begin fails++; $display("FAIL push_y: y=%h expected %h", y, 8'h20); end
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(OP_RFCT, 1'b0, 1'b1, 8'h00);
            tests_run++;
            if (y !== exp_seq[i]) begin fails++; $display("FAIL rfct[%0d]: y=%h expected %h", i, y, exp_seq[i]); end
            tick();
        end
        drive(OP_CRTN, 1'b1, 1'b1, 8'h00);
        tests_run++;
        if (y !== 8'h00) begin fails++; $display("FAIL rfct_popped: y=%h expected %h", y, 8'h00); end
        tick();
        drive(OP_LDCT, 1'b0, 1'b1, 8'h01); tick();
        drive(OP_RPCT, 1'b0, 1'b1, 8'h50);
        tests_run++;
        if (y !== 8'h50) begin fails++; $display("FAIL rpct_taken: y=%h expected %h", y, 8'h50); end
        tick();
        drive(OP_RPCT, 1'b0, 1'b1, 8'h50);
        tests_run++;
        if (y !== 8'h51) begin fails++; $display("FAIL rpct_done: y=%h expected %h", y, 8'h51); end
        tick();
    endtask

    task automatic test_stack_bounds();
        logic [7:0] exp_ret [6];
        exp_ret[0] = 8'h15; exp_ret[1] = 8'h13; exp_ret[2] = 8'h12;
        exp_ret[3] = 8'h11; exp_ret[4] = 8'h10; exp_ret[5] = 8'h00;
        do_reset();
        drive(OP_CJP, 1'b1, 1'b1, 8'h0F); tick();
        for (int i = 0; i < 6; i++) begin
            drive(OP_PUSH, 1'b0, 1'b1, 8'h00); tick();
            tests_run++;
            if (full !== (i >= 4)) begin fails++; $display("FAIL full_after_push[%0d]: full=%b expected %b", i, full, (i >= 4)); end
        end
        for (int i = 0; i < 6; i++) begin
            drive(OP_CRTN, 1'b1, 1'b1, 8'h00);
            tests_run++;
            if (y !== exp_ret[i]) begin fails++; $display("FAIL return[%0d]: y=%h expected %h", i, y, exp_ret[i]); end
            tick();
            tests_run++;
            if (full !== 1'b0) begin fails++; $display("FAIL full_after_pop[%0d]: full=%b expected 0", i, full); end
        end
    endtask

    task automatic test_twb();
        do_reset();
        drive(OP_CJP, 1'b1, 1'b1, 8'h2F); tick();
        drive(OP_PUSH, 1'b1, 1'b1, 8'h01); tick();
        drive(OP_PUSH, 1'b0, 1'b1, 8'h00); tick();
        drive(OP_PUSH, 1'b0, 1'b1, 8'h00); tick();
        drive(OP_TWB, 1'b0, 1'b0, 8'h77);
        tests_run++;
        if (y !== 8'h32) begin fails++; $display("FAIL twb_count: y=%h expected %h", y, 8'h32); end
        tick();
        drive(OP_TWB, 1'b0, 1'b1, 8'h33);
        tests_run++;
        if (y !== 8'h33) begin fails++; $display("FAIL twb_exhausted: y=%h expected %h", y, 8'h33); end
        tick();
        drive(OP_TWB, 1'b1, 1'b1, 8'h77);
        tests_run++;
        if (y !== 8'h34) begin fails++; $display("FAIL twb_pass: y=%h expected %h", y, 8'h34); end
        tick();
        drive(OP_CRTN, 1'b1, 1'b1, 8'h00);
        tests_run++;
        if (y !== 8'h30) begin fails++; $display("FAIL twb_pops: y=%h expected %h", y, 8'h30); end
        tick();
    endtask

    task automatic test_wrap_enables();
        do_reset();
        drive(OP_JMAP, 1'b0, 1'b0, 8'hFF);
        tests_run++;
        if (y !== 8'hFF || map_en !== 1'b1 || pl_en !== 1'b0 || vect_en !== 1'b0) begin
            fails++; $display("FAIL jmap: y=%h map=%b pl=%b vect=%b expected y=ff map=1 pl=0 vect=0", y, map_en, pl_en, vect_en);
        end
        tick();
        drive(OP_CONT, 1'b0, 1'b1, 8'h00); tick();
        drive(OP_CONT, 1'b0, 1'b1, 8'h00);
        tests_run++;
        if (y !== 8'h00 || pl_en !== 1'b1) begin fails++; $display("FAIL upc_wrap: y=%h pl=%b expected y=00 pl=1", y, pl_en); end
        tick();
        drive(OP_CJV, 1'b1, 1'b1, 8'h55);
        tests_run++;
        if (y !== 8'h55 || vect_en !== 1'b1 || pl_en !== 1'b0 || map_en !== 1'b0) begin
            fails++; $display("FAIL cjv_pass: y=%h vect=%b pl=%b map=%b expected y=55 vect=1 pl=0 map=0", y, vect_en, pl_en, map_en);
        end
        tick();
        drive(OP_CJV, 1'b0, 1'b1, 8'h55);
        tests_run++;
        if (y !== 8'h56) begin fails++; $display("FAIL cjv_fail: y=%h expected %h", y, 8'h56); end
        tick();
        drive(OP_PUSH, 1'b0, 1'b1, 8'h00); tick();
        drive(OP_JZ, 1'b1, 1'b1, 8'h99);
        tests_run++;
        if (y !== 8'h00 || pl_en !== 1'b1) begin fails++; $display("FAIL jz: y=%h pl=%b expected y=00 pl=1", y, pl_en); end
        tick();
        drive(OP_CRTN, 1'b1, 1'b1, 8'h00);
        tests_run++;
        if (y !== 8'h00) begin fails++; $display("FAIL jz_clear: y=%h expected %h", y, 8'h00); end
        tick();
    endtask

    initial begin
        rst_n = 1'b0; inst = 4'd14; cond = 1'b0; ci = 1'b0; d = 8'h00;
        @(negedge clk);
        test_reset();
        test_subroutine();
        test_counted_loop();
        test_stack_bounds();
        test_twb();
        test_wrap_enables();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Microprogram sequencer (Am2910-class) for the Am2901 clone datapath. Each cycle it picks the next microaddress `y` from the incrementer, the direct input `d`, the loop register or the subroutine stack, according to a 4-bit sequence instruction and a test condition. `y` indexes the microcode ROM. The ROM word, held in the external pipeline register, drives the ALU slice controller's `i[8:0]`, `a`, `b` and the next `inst`/`d` fields of this block.

## Interface
- `AW`, default 8: microaddress, `d`, `upc` and counter width.
- `DEPTH`, default 5: subroutine/loop stack entries.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `inst`  in  4: sequence instruction from the pipeline register.
- `cond`  in  1: test input; 1 = pass.
- `ci`  in  1: incrementer carry-in; 1 = `upc <= y+1`, 0 = `upc <= y`.
- `d`  in  AW: branch address or count, from the pipeline or map/vector source.
- `y`  out  AW: next microaddress, combinational.
- `pl_en`, `map_en`, `vect_en`  out  1 each: one-hot source enables for `d`. `map_en` is high for JMAP, `vect_en` for CJV, `pl_en` otherwise.
- `full`  out  1: stack holds `DEPTH` entries.

## Operation
- State:
  - `upc`, AW bits.
  - Counter `r`, AW bits.
  - Stack `stk[DEPTH]` with pointer `sp` in 0..DEPTH; `tos = stk[sp-1]`, or 0 when `sp==0`.
- Every edge: `upc <= y + ci`, modulo 2^AW (`'1 + 1` wraps to 0).
- "push" writes the current `upc`.
- Instructions, each written as `y` on pass / `y` on fail, followed by side effects:
  - 0 JZ: `y=0` always; `sp<=0`.
  - 1 CJS: `d` / `upc`; push on pass.
  - 2 JMAP: `d` always.
  - 3 CJP: `d` / `upc`.
  - 4 PUSH: `y=upc`; push always; `r<=d` on pass.
  - 5 JSRP: `d` / `r`; push always.
  - 6 CJV: `d` / `upc`.
  - 7 JRP: `d` / `r`.
  - 8 RFCT: depends on `r`, not `cond`.
    - `r!=0`: `y=tos`, `r<=r-1`.
    - `r==0`: `y=upc`, pop.
  - 9 RPCT: depends on `r`, not `cond`.
    - `r!=0`: `y=d`, `r<=r-1`.
    - `r==0`: `y=upc`.
  - 10 CRTN: `tos` / `upc`; pop on pass.
  - 11 CJPP: `d` / `upc`; pop on pass.
  - 12 LDCT: `y=upc`; `r<=d`.
  - 13 LOOP: `upc` / `tos`; pop on pass.
  - 14 CONT: `y=upc`.
  - 15 TWB:
    - pass: `y=upc`, pop.
    - fail, `r!=0`: `y=tos`, `r<=r-1`.
    - fail, `r==0`: `y=d`, pop.
- `r` never decrements below 0.
- Push when full: overwrite `stk[DEPTH-1]`; `sp` unchanged; `full` stays 1.
- Pop when empty: no state change.
- No instruction both pushes and pops.
- PUSH with pass loads `r` and pushes in the same edge.
- `full = (sp==DEPTH)`.

## Timing
- `y`, `pl_en`, `map_en`, `vect_en` are combinational from `inst`, `cond`, `d` and current state, valid in the same cycle.
- All state changes land at the next rising edge; the pushed value is `upc` before that edge.
- Reset (`rst_n` low, asynchronous, including mid-instruction):
  - `upc=0`, `r=0`, `sp=0`, stack contents 0.
  - `y=0` while `rst_n` is low; `full=0`; `pl_en=1`.
- First edge after release executes the presented `inst` normally.
- Single-cycle throughput: one instruction per clock, no stalls.
- Hold the microaddress by driving `ci=0` with CONT.

## Structure
- Package `micro_seq_pkg`: `seq_op_t` enum for the 16 opcodes (values 0..15 as listed), plus `AW` and `DEPTH` defaults.
- Sub-module `seq_stack`: parameterised LIFO with push, pop, clear, `tos`, `full`, `empty`, and the overwrite/underflow rules above.
- Top level holds `upc`, `r`, the opcode decode and the `y` mux.

## Test plan
- Reset mid-run: `rst_n` low during RFCT with `r=3`, `sp=2` → `y=0`, `full=0` at once; after release, CONT with `ci=1` gives `y` = 0, 1, 2.
- Subroutine: at `upc=0x10`, CJS `d=0x40` `cond=1` → `y=0x40`, `tos=0x10`. At `upc=0x42`, CRTN `cond=1` → `y=0x10`, `sp=0`. With `cond=0`, CRTN → `y=upc`, stack unchanged.
- Counted loop: LDCT `d=2`, PUSH at `upc=0x20`, then RFCT repeatedly → `y` = `tos`, `tos`, `upc`. `r` steps 2→1→0, then pop.
- Stack boundaries: 6 pushes with DEPTH=5 → `full=1` after the 5th; the 6th overwrites the top. 6 CRTN pass → 5 distinct returns, and the 6th leaves state unchanged with `y=0`.
- TWB: check all three branches.
  - `r=1`, `cond=0` → `y=tos`, `r=0`.
  - `r=0`, `cond=0`, `d=0x33` → `y=0x33`, pop.
  - `cond=1` → `y=upc`, pop.
- Wrap and enables: `upc=0xFF`, CONT → next `y=0x00`. JMAP → `map_en=1` only; CJV → `vect_en=1` only; JZ → `y=0`, `sp=0`.
